// File: rtl/rom_load_sequencer_if.sv
// HPS ioctl download bus as seen by the ROM load sequencer.
// The HPS side drives every signal; the sequencer only observes.
interface rom_load_sequencer_if;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;

    modport master (output ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout);
    modport slave  (input  ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout);
endinterface

// File: rtl/rom_load_sequencer.sv
// ROM download decoder and core reset sequencer for the Blockade-family core:
// splits ioctl writes into program/graphics strobes, verifies the image, then releases core reset.
module rom_load_sequencer #(
    parameter int PROG_SIZE   = 4096,
    parameter int GFX_SIZE    = 1024,
    parameter int HOLD_CYCLES = 1024,
    parameter int CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    rom_load_sequencer_if.slave     ioctl,
    input  logic                    user_reset,
    output logic                    prog_we,
    output logic                    gfx_we,
    output logic [13:0]             dn_addr,
    output logic [7:0]              dn_data,
    output logic [1:0]              game_mode,
    output logic                    core_reset,
    output logic                    rom_valid,
    output logic                    loading,
    output logic [CNT_W-1:0]        byte_count
);
    localparam int                HOLD_W    = $clog2(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [24:0]       PROG_END  = 25'(PROG_SIZE);
    localparam logic [24:0]       GFX_END   = 25'(PROG_SIZE + GFX_SIZE);

    typedef enum logic [2:0] {IDLE, LOAD, VERIFY, HOLD, RUN} state_t;

    state_t            state_reg, state_next;
    logic [HOLD_W-1:0] hold_reg, hold_next;
    logic [CNT_W-1:0]  byte_count_reg, byte_count_next;
    logic              nonzero_reg, nonzero_next;
    logic              rom_valid_reg, rom_valid_next;
    logic              prog_we_reg, prog_we_next;
    logic              gfx_we_reg, gfx_we_next;
    logic [13:0]       dn_addr_reg, dn_addr_next;
    logic [7:0]        dn_data_reg, dn_data_next;
    logic [1:0]        game_mode_reg, game_mode_next;
    logic              loading_reg, loading_next;
    logic              core_reset_reg, core_reset_next;
    logic              dl_prev_reg;

    logic rom_wr, mode_wr, dl_start;

    // Only a rising edge of download starts a load, so a download interrupted by reset stays ignored.
    assign rom_wr   = ioctl.ioctl_wr && (ioctl.ioctl_index == 8'd0);
    assign mode_wr  = ioctl.ioctl_wr && (ioctl.ioctl_index == 8'd1);
    assign dl_start = ioctl.ioctl_download && !dl_prev_reg && (ioctl.ioctl_index == 8'd0);

    always_comb begin
        state_next      = state_reg;
        hold_next       = hold_reg;
        byte_count_next = byte_count_reg;
        nonzero_next    = nonzero_reg;
        rom_valid_next  = rom_valid_reg;
        prog_we_next    = 1'b0;
        gfx_we_next     = 1'b0;
        dn_addr_next    = dn_addr_reg;
        dn_data_next    = dn_data_reg;
        game_mode_next  = game_mode_reg;

        if (mode_wr)
            game_mode_next = ioctl.ioctl_dout[1:0];

        if (dl_start) begin
            state_next      = LOAD;
            byte_count_next = '0;
            nonzero_next    = 1'b0;
            rom_valid_next  = 1'b0;
        end else begin
            case (state_reg)
                LOAD: begin
                    if (rom_wr) begin
                        if (byte_count_reg != '1)
                            byte_count_next = byte_count_reg + 1'b1;
                        if (ioctl.ioctl_dout != 8'd0)
                            nonzero_next = 1'b1;
                        dn_data_next = ioctl.ioctl_dout;
                        if (ioctl.ioctl_addr < PROG_END) begin
                            prog_we_next = 1'b1;
                            dn_addr_next = ioctl.ioctl_addr[13:0];
                        end else if (ioctl.ioctl_addr < GFX_END) begin
                            gfx_we_next  = 1'b1;
                            dn_addr_next = ioctl.ioctl_addr[13:0] - PROG_END[13:0];
                        end
                    end
                    if (!ioctl.ioctl_download)
                        state_next = VERIFY;
                end
                VERIFY: begin
                    if (nonzero_reg && (int'(byte_count_reg) >= PROG_SIZE)) begin
                        rom_valid_next = 1'b1;
                        state_next     = HOLD;
                        hold_next      = HOLD_LOAD;
                    end else begin
                        rom_valid_next = 1'b0;
                        state_next     = IDLE;
                    end
                end
                HOLD: begin
                    // Leaving at count 1 makes core_reset fall exactly HOLD_CYCLES after the load/restart edge.
                    if (user_reset || mode_wr) begin
                        hold_next = HOLD_LOAD;
                    end else if (hold_reg <= HOLD_W'(1)) begin
                        hold_next  = '0;
                        state_next = RUN;
                    end else begin
                        hold_next = hold_reg - 1'b1;
                    end
                end
                RUN: begin
                    if (user_reset || mode_wr) begin
                        state_next = HOLD;
                        hold_next  = HOLD_LOAD;
                    end
                end
                default: ;
            endcase
        end

        loading_next    = (state_next == LOAD);
        core_reset_next = (state_reg != RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            hold_reg       <= '0;
            byte_count_reg <= '0;
            nonzero_reg    <= 1'b0;
            rom_valid_reg  <= 1'b0;
            prog_we_reg    <= 1'b0;
            gfx_we_reg     <= 1'b0;
            dn_addr_reg    <= '0;
            dn_data_reg    <= '0;
            game_mode_reg  <= '0;
            loading_reg    <= 1'b0;
            core_reset_reg <= 1'b1;
            dl_prev_reg    <= 1'b1;
        end else begin
            state_reg      <= state_next;
            hold_reg       <= hold_next;
            byte_count_reg <= byte_count_next;
            nonzero_reg    <= nonzero_next;
            rom_valid_reg  <= rom_valid_next;
            prog_we_reg    <= prog_we_next;
            gfx_we_reg     <= gfx_we_next;
            dn_addr_reg    <= dn_addr_next;
            dn_data_reg    <= dn_data_next;
            game_mode_reg  <= game_mode_next;
            loading_reg    <= loading_next;
            core_reset_reg <= core_reset_next;
            dl_prev_reg    <= ioctl.ioctl_download;
        end
    end

    assign prog_we    = prog_we_reg;
    assign gfx_we     = gfx_we_reg;
    assign dn_addr    = dn_addr_reg;
    assign dn_data    = dn_data_reg;
    assign game_mode  = game_mode_reg;
    assign core_reset = core_reset_reg;
    assign rom_valid  = rom_valid_reg;
    assign loading    = loading_reg;
    assign byte_count = byte_count_reg;
endmodule

// File: tb/tb_rom_load_sequencer.sv
// Directed bench for rom_load_sequencer: a full-size instance plus a tiny one
// (4-bit counter, 2-cycle hold) sharing the same ioctl bus for saturation and minimum-hold cases.
module tb_rom_load_sequencer;
    localparam int H = 1024;

    logic clk, reset, user_reset;
    rom_load_sequencer_if bus();

    logic        prog_we, gfx_we, core_reset, rom_valid, loading;
    logic [13:0] dn_addr;
    logic [7:0]  dn_data;
    logic [1:0]  game_mode;
    logic [15:0] byte_count;

    logic        prog_we_s, gfx_we_s, core_reset_s, rom_valid_s, loading_s;
    logic [13:0] dn_addr_s;
    logic [7:0]  dn_data_s;
    logic [1:0]  game_mode_s;
    logic [3:0]  byte_count_s;

    int checks = 0;
    int errors = 0;

    rom_load_sequencer dut (
        .clk(clk), .reset(reset), .ioctl(bus.slave), .user_reset(user_reset),
        .prog_we(prog_we), .gfx_we(gfx_we), .dn_addr(dn_addr), .dn_data(dn_data),
        .game_mode(game_mode), .core_reset(core_reset), .rom_valid(rom_valid),
        .loading(loading), .byte_count(byte_count)
    );

    rom_load_sequencer #(.PROG_SIZE(4), .GFX_SIZE(4), .HOLD_CYCLES(2), .CNT_W(4)) dut_s (
        .clk(clk), .reset(reset), .ioctl(bus.slave), .user_reset(user_reset),
        .prog_we(prog_we_s), .gfx_we(gfx_we_s), .dn_addr(dn_addr_s), .dn_data(dn_data_s),
        .game_mode(game_mode_s), .core_reset(core_reset_s), .rom_valid(rom_valid_s),
        .loading(loading_s), .byte_count(byte_count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_byte(input logic [7:0] idx, input int addr, input logic [7:0] data);
        bus.ioctl_wr    = 1'b1;
        bus.ioctl_index = idx;
        bus.ioctl_addr  = 25'(addr);
        bus.ioctl_dout  = data;
        tick();
        bus.ioctl_wr = 1'b0;
    endtask

    task automatic start_dl();
        bus.ioctl_index    = 8'd0;
        bus.ioctl_download = 1'b1;
        tick();
    endtask

    task automatic end_dl();
        bus.ioctl_download = 1'b0;
        tick();
    endtask

    task automatic load_fill(input int n, input int nz, input logic [7:0] val);
        for (int i = 0; i < n; i++)
            wr_byte(8'd0, i, (i < nz) ? val : 8'h00);
    endtask

    task automatic test_reset();
        int bad;
        #2;
        checks++;
        if (core_reset !== 1'b1 || rom_valid !== 1'b0 || loading !== 1'b0 || prog_we !== 1'b0 ||
            gfx_we !== 1'b0 || byte_count !== 16'd0 || dn_addr !== 14'd0 || dn_data !== 8'd0 ||
            game_mode !== 2'd0) begin
            errors++;
            $display("FAIL reset_values: got cr=%b rv=%b ld=%b pw=%b gw=%b bc=%0d da=%0d dd=%0h gm=%0d required cr=1 others 0",
                     core_reset, rom_valid, loading, prog_we, gfx_we, byte_count, dn_addr, dn_data, game_mode);
        end
        tick(); tick();
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            user_reset = (i == 500);
            tick();
            if (core_reset !== 1'b1 || rom_valid !== 1'b0) bad++;
        end
        user_reset = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL boot_idle: got %0d cycles with core_reset low or rom_valid high, required 0", bad);
        end
        wr_byte(8'd1, 0, 8'h02);
        checks++;
        if (game_mode !== 2'd2) begin
            errors++;
            $display("FAIL idle_game_mode: got %0d required 2", game_mode);
        end
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (core_reset !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_mode_write_reset: got %0d cycles core_reset low, required 0", bad);
        end
        $display("test_reset: idle boot, core_reset=%b rom_valid=%b game_mode=%0d", core_reset, rom_valid, game_mode);
    endtask

    task automatic test_full_load();
        int k;
        logic        ep, eg;
        logic [13:0] ea;
        start_dl();
        checks++;
        if (loading !== 1'b1 || rom_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_entry: got loading=%b rom_valid=%b required 1 0", loading, rom_valid);
        end
        for (int i = 0; i < 5120; i++) begin
            wr_byte(8'd0, i, 8'hA5);
            ep = (i < 4096);
            eg = !ep;
            ea = ep ? 14'(i) : 14'(i - 4096);
            checks++;
            if (prog_we !== ep || gfx_we !== eg || dn_addr !== ea || dn_data !== 8'hA5) begin
                errors++;
                $display("FAIL strobe_addr%0d: got pw=%b gw=%b da=%0d dd=%0h required pw=%b gw=%b da=%0d dd=a5",
                         i, prog_we, gfx_we, dn_addr, dn_data, ep, eg, ea);
            end
        end
        tick();
        checks++;
        if (prog_we !== 1'b0 || gfx_we !== 1'b0 || byte_count !== 16'd5120 || byte_count_s !== 4'hF) begin
            errors++;
            $display("FAIL load_tail: got pw=%b gw=%b bc=%0d bc_s=%0d required 0 0 5120 15",
                     prog_we, gfx_we, byte_count, byte_count_s);
        end
        end_dl();
        checks++;
        if (loading !== 1'b0 || rom_valid !== 1'b0) begin
            errors++;
            $display("FAIL verify_entry: got loading=%b rom_valid=%b required 0 0", loading, rom_valid);
        end
        tick();
        checks++;
        if (rom_valid !== 1'b1 || core_reset !== 1'b1 || rom_valid_s !== 1'b1) begin
            errors++;
            $display("FAIL verify_pass: got rom_valid=%b core_reset=%b rom_valid_s=%b required 1 1 1",
                     rom_valid, core_reset, rom_valid_s);
        end
        k = 0;
        while (core_reset !== 1'b0 && k < 2 * H) begin
            tick();
            k++;
        end
        checks++;
        if (k != H) begin
            errors++;
            $display("FAIL load_hold_len: got %0d cycles required %0d", k, H);
        end
        $display("test_full_load: 5120 bytes, rom_valid=%b, core_reset fell after %0d cycles", rom_valid, k);
    endtask

    task automatic test_game_mode();
        int k;
        wr_byte(8'd1, 0, 8'h03);
        checks++;
        if (game_mode !== 2'd3) begin
            errors++;
            $display("FAIL run_game_mode: got %0d required 3", game_mode);
        end
        tick();
        k = 1;
        checks++;
        if (core_reset !== 1'b1) begin
            errors++;
            $display("FAIL mode_reset_rise: got %b required 1", core_reset);
        end
        while (core_reset !== 1'b0 && k < 2 * H) begin
            tick();
            k++;
        end
        checks++;
        if (k != H) begin
            errors++;
            $display("FAIL mode_hold_len: got %0d cycles required %0d", k, H);
        end
        $display("test_game_mode: game_mode=%0d, core_reset fell after %0d cycles", game_mode, k);

        wr_byte(8'd1, 0, 8'h01);
        for (int i = 0; i < 500; i++) tick();
        user_reset = 1'b1;
        tick();
        user_reset = 1'b0;
        k = 0;
        while (core_reset !== 1'b0 && k < 2 * H) begin
            tick();
            k++;
        end
        checks++;
        if (k != H || game_mode !== 2'd1) begin
            errors++;
            $display("FAIL user_reset_hold_len: got %0d cycles gm=%0d required %0d cycles gm=1", k, game_mode, H);
        end
        $display("test_user_reset: hold restarted, core_reset fell %0d cycles after pulse", k);
    endtask

    task automatic test_bad_images();
        int bad;
        start_dl();
        checks++;
        if (rom_valid !== 1'b0) begin
            errors++;
            $display("FAIL reload_clears_valid: got %b required 0", rom_valid);
        end
        load_fill(5120, 0, 8'h00);
        end_dl();
        tick();
        bad = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (core_reset !== 1'b1 || rom_valid !== 1'b0 || loading !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL empty_image: got %0d bad cycles required 0", bad);
        end
        $display("test_empty: 5120 zero bytes, rom_valid=%b core_reset=%b", rom_valid, core_reset);

        start_dl();
        load_fill(100, 100, 8'h5A);
        end_dl();
        tick();
        checks++;
        if (rom_valid !== 1'b0 || byte_count !== 16'd100) begin
            errors++;
            $display("FAIL short_image: got rom_valid=%b bc=%0d required 0 100", rom_valid, byte_count);
        end
        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (core_reset !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL short_image_reset: got %0d cycles core_reset low required 0", bad);
        end
        $display("test_short: 100 bytes, rom_valid=%b byte_count=%0d", rom_valid, byte_count);
    endtask

    task automatic test_decode_and_saturation();
        start_dl();
        wr_byte(8'd0, 6000, 8'h11);
        checks++;
        if (prog_we !== 1'b0 || gfx_we !== 1'b0 || byte_count !== 16'd1) begin
            errors++;
            $display("FAIL out_of_range: got pw=%b gw=%b bc=%0d required 0 0 1", prog_we, gfx_we, byte_count);
        end
        wr_byte(8'd0, 4095, 8'h11);
        checks++;
        if (prog_we !== 1'b1 || gfx_we !== 1'b0 || dn_addr !== 14'd4095) begin
            errors++;
            $display("FAIL prog_last: got pw=%b gw=%b da=%0d required 1 0 4095", prog_we, gfx_we, dn_addr);
        end
        wr_byte(8'd0, 4096, 8'h11);
        checks++;
        if (prog_we !== 1'b0 || gfx_we !== 1'b1 || dn_addr !== 14'd0) begin
            errors++;
            $display("FAIL gfx_first: got pw=%b gw=%b da=%0d required 0 1 0", prog_we, gfx_we, dn_addr);
        end
        wr_byte(8'd0, 5119, 8'h11);
        checks++;
        if (gfx_we !== 1'b1 || dn_addr !== 14'd1023) begin
            errors++;
            $display("FAIL gfx_last: got gw=%b da=%0d required 1 1023", gfx_we, dn_addr);
        end
        wr_byte(8'd0, 5120, 8'h11);
        checks++;
        if (prog_we !== 1'b0 || gfx_we !== 1'b0 || byte_count !== 16'd5) begin
            errors++;
            $display("FAIL past_gfx: got pw=%b gw=%b bc=%0d required 0 0 5", prog_we, gfx_we, byte_count);
        end
        wr_byte(8'd1, 0, 8'h02);
        checks++;
        if (byte_count !== 16'd5 || game_mode !== 2'd2 || prog_we !== 1'b0) begin
            errors++;
            $display("FAIL mode_in_load: got bc=%0d gm=%0d pw=%b required 5 2 0", byte_count, game_mode, prog_we);
        end
        for (int i = 0; i < 9; i++) wr_byte(8'd0, 0, 8'h11);
        checks++;
        if (byte_count_s !== 4'hE || byte_count !== 16'd14) begin
            errors++;
            $display("FAIL count_near_full: got bc_s=%0d bc=%0d required 14 14", byte_count_s, byte_count);
        end
        for (int i = 0; i < 3; i++) wr_byte(8'd0, 0, 8'h11);
        checks++;
        if (byte_count_s !== 4'hF || byte_count !== 16'd17) begin
            errors++;
            $display("FAIL count_saturate: got bc_s=%0d bc=%0d required 15 17", byte_count_s, byte_count);
        end
        end_dl();
        tick();
        checks++;
        if (rom_valid_s !== 1'b1 || rom_valid !== 1'b0) begin
            errors++;
            $display("FAIL small_verify: got rv_s=%b rv=%b required 1 0", rom_valid_s, rom_valid);
        end
        tick();
        checks++;
        if (core_reset_s !== 1'b1) begin
            errors++;
            $display("FAIL min_hold_high: got %b required 1", core_reset_s);
        end
        tick();
        checks++;
        if (core_reset_s !== 1'b0) begin
            errors++;
            $display("FAIL min_hold_release: got %b required 0", core_reset_s);
        end
        $display("test_decode_and_saturation: bc=%0d bc_s=%0d core_reset_s=%b", byte_count, byte_count_s, core_reset_s);
    endtask

    task automatic test_async_reset();
        int bad;
        int k;
        start_dl();
        tick();
        checks++;
        if (core_reset_s !== 1'b1 || loading_s !== 1'b1) begin
            errors++;
            $display("FAIL run_to_load: got cr_s=%b ld_s=%b required 1 1", core_reset_s, loading_s);
        end
        load_fill(2000, 2000, 8'hA5);
        reset = 1'b1;
        #1;
        checks++;
        if (core_reset !== 1'b1 || loading !== 1'b0 || byte_count !== 16'd0 || prog_we !== 1'b0 ||
            dn_addr !== 14'd0 || dn_data !== 8'd0 || rom_valid !== 1'b0 || game_mode !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: got cr=%b ld=%b bc=%0d pw=%b da=%0d dd=%0h rv=%b gm=%0d required cr=1 others 0",
                     core_reset, loading, byte_count, prog_we, dn_addr, dn_data, rom_valid, game_mode);
        end
        tick(); tick();
        reset = 1'b0;
        bad = 0;
        for (int i = 2000; i < 2100; i++) begin
            wr_byte(8'd0, i, 8'hA5);
            if (prog_we !== 1'b0 || gfx_we !== 1'b0 || loading !== 1'b0 || byte_count !== 16'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL post_reset_ignored: got %0d active writes required 0", bad);
        end
        end_dl();
        start_dl();
        load_fill(5120, 5120, 8'h3C);
        end_dl();
        tick();
        checks++;
        if (rom_valid !== 1'b1 || byte_count !== 16'd5120) begin
            errors++;
            $display("FAIL reload_after_reset: got rv=%b bc=%0d required 1 5120", rom_valid, byte_count);
        end
        k = 0;
        while (core_reset !== 1'b0 && k < 2 * H) begin
            tick();
            k++;
        end
        checks++;
        if (k != H) begin
            errors++;
            $display("FAIL reload_hold_len: got %0d cycles required %0d", k, H);
        end
        $display("test_async_reset: reload rom_valid=%b, core_reset fell after %0d cycles", rom_valid, k);
    endtask

    initial begin
        reset              = 1'b1;
        user_reset         = 1'b0;
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_index    = 8'd0;
        bus.ioctl_addr     = 25'd0;
        bus.ioctl_dout     = 8'd0;
        test_reset();
        test_full_load();
        test_game_mode();
        test_bad_images();
        test_decode_and_saturation();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rom_load_sequencer.md
Name: rom_load_sequencer

Overview:
- Owns the ROM download path and core reset sequencing for the Blockade-family core, between the HPS ioctl bus and the game core's download/reset inputs.
- Decodes ioctl writes into per-region ROM write strobes (program, graphics) and latches the game-mode byte.
- Verifies that a usable image arrived, then releases the core from reset after a fixed hold-off.
- Keeps the core in reset (and sound silent) when no ROM or an empty ROM was delivered.

Parameters:
- PROG_SIZE, 4096, bytes in program ROM region, starting at download address 0.
- GFX_SIZE, 1024, bytes in graphics region, immediately after program region.
- HOLD_CYCLES, 1024, clk cycles core_reset stays high after a successful load or a user reset; must be ≥2.
- CNT_W, 16, width of byte_count.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ioctl_download  in  1  HPS download active.
- ioctl_wr  in  1  one-cycle write strobe.
- ioctl_index  in  8  0 = ROM image, 1 = game-mode byte, others ignored.
- ioctl_addr  in  25  byte address within the current download.
- ioctl_dout  in  8  download data.
- user_reset  in  1  OSD/button reset request, level.
- prog_we  out  1  program ROM write strobe.
- gfx_we  out  1  graphics ROM write strobe.
- dn_addr  out  14  region-relative write address.
- dn_data  out  8  write data.
- game_mode  out  2  latched game select.
- core_reset  out  1  reset to game core.
- rom_valid  out  1  last ROM download passed verification.
- loading  out  1  ROM download in progress (drives LED).
- byte_count  out  CNT_W  bytes accepted in the current/last ROM download, saturating.

Behaviour:
- Reset values: prog_we=0, gfx_we=0, dn_addr=0, dn_data=0, game_mode=0, core_reset=1, rom_valid=0, loading=0, byte_count=0, state=IDLE, hold counter=0.
- States: IDLE (no valid ROM), LOAD, VERIFY, HOLD, RUN. core_reset=1 in every state except RUN. A registered value is used, so core_reset falls in the cycle after entering RUN.
- Any state to LOAD: on ioctl_download=1 with ioctl_index=0. On entry, byte_count=0, nonzero flag cleared, rom_valid=0, loading=1.
- LOAD write decode, for each ioctl_wr with index 0:
  - addr < PROG_SIZE: prog_we pulses, dn_addr=addr.
  - PROG_SIZE ≤ addr < PROG_SIZE+GFX_SIZE: gfx_we pulses, dn_addr=addr−PROG_SIZE.
  - addr beyond the graphics region: no strobe, byte still counted.
  - dn_data=ioctl_dout in every decoded case.
  - Latency: exactly one clk from ioctl_wr to the strobe. The strobe is one cycle wide. Never both strobes in the same cycle.
- byte_count increments per accepted write and saturates at all-ones, no wrap. The nonzero flag sets if any ioctl_dout≠0.
- LOAD to VERIFY: when ioctl_download falls. loading drops in the same cycle the state leaves LOAD.
- VERIFY, one cycle:
  - nonzero flag=1 and byte_count ≥ PROG_SIZE: rom_valid=1, go to HOLD.
  - Otherwise: rom_valid=0, go to IDLE.
- HOLD: counter loads HOLD_CYCLES−1 on entry and decrements to 0, then goes to RUN. Total core_reset high time after VERIFY is exactly HOLD_CYCLES cycles. user_reset high in HOLD reloads the counter.
- RUN: user_reset=1 goes to HOLD. A game-mode write also goes to HOLD.
- Game mode: ioctl_wr with index 1 latches game_mode=ioctl_dout[1:0] in any state, effective next cycle.
  - In IDLE, the write has no further effect.
  - In RUN or HOLD, it forces or restarts HOLD.
- IDLE: ignores user_reset and stays in reset until a valid ROM load.
- Simultaneous events:
  - Download start beats user_reset.
  - ioctl_wr with index≠0 during LOAD is ignored for ROM, but an index-1 write still latches game_mode.
- Download start while in HOLD/RUN: immediately LOAD, core_reset=1 the next cycle.
- Async reset mid-download: all state returns to reset values. The remainder of that download is ignored until a new ioctl_download rising with index 0.

Test Plan:
- Boot without download → core_reset stays 1 for 100k cycles; rom_valid=0.
- Download 5120 bytes of 0xA5, index 0 → 4096 prog_we pulses with dn_addr 0..4095, then 1024 gfx_we pulses with dn_addr 0..1023. Each strobe comes 1 cycle after ioctl_wr. rom_valid=1 one cycle after download falls; core_reset falls exactly HOLD_CYCLES cycles later.
- Download 5120 bytes all 0x00 → rom_valid=0, state IDLE, core_reset stays 1. Repeat with only 100 nonzero bytes → rom_valid=0 (short image).
- In RUN, write index 1 data 0x03 → game_mode=3 next cycle, core_reset high for HOLD_CYCLES, then low. A user_reset pulse mid-HOLD extends the hold by a full HOLD_CYCLES from the pulse.
- Write addr 6000 during LOAD → no strobe, byte_count increments. Force byte_count to 0xFFFE, write 3 more bytes → byte_count=0xFFFF.
- Assert async reset at byte 2000 of a download → outputs return to reset values at once. The remaining writes produce no strobes; a new download then completes normally.
